pcr_valve_sequencer: RTL and testbench
======================================

Name: pcr_valve_sequencer

Overview:
Clocked pneumatic controller that drives the two air-control lines of the PCR mixing chip: the reagent-load valve (valve0 path) and the bypass valve (valve1 path).
It runs a fixed per-run sequence (load, dead-time, bypass, settle) and repeats it for a requested number of runs.
It sits directly upstream of the chip's in_air0/in_air1 pins and is the only block that actuates them.
Polarity: air line = 1 means pressurised, which closes the valve.

Parameters:
TIMER_W, 16, width of the phase timer
RUNS_W, 8, width of the run count and run index
LOAD_CYCLES, 1000, cycles valve0 is held open per run (must be >= 1)
DEAD_CYCLES, 4, cycles with both valves closed between load and bypass (must be >= 1)
BYPASS_CYCLES, 1000, cycles valve1 is held open per run (must be >= 1)
SETTLE_CYCLES, 200, cycles with both valves closed at the end of each run (must be >= 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request a sequence; sampled only in IDLE
n_runs  input  RUNS_W  number of runs; latched when start is accepted
air_ctrl0  output  1  drives chip in_air0; 0 = valve0 open
air_ctrl1  output  1  drives chip in_air1; 0 = valve1 open
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse marking the end of a sequence
run_idx  output  RUNS_W  index of the current run, counting from 0

Behaviour:
- Clock and reset: single clock clk; all outputs registered. rst is synchronous and active-high.
- Reset state: state=IDLE, air_ctrl0=1, air_ctrl1=1, busy=0, done=0, run_idx=0, timer=0.
- Reset mid-sequence: at the next edge both valves close and all state returns to the reset values.
- States: IDLE, LOAD, DEAD, BYPASS, SETTLE, DONE.
- IDLE, start=1, n_runs!=0:
  - latch n_runs, clear run_idx;
  - next state LOAD with air_ctrl0=0 in the same registered update;
  - busy=1.
- IDLE, start=1, n_runs==0: go to DONE without touching the valves. done pulses one cycle later.
- LOAD: air_ctrl0=0, air_ctrl1=1 for exactly LOAD_CYCLES cycles, then DEAD.
- DEAD: both lines 1 for DEAD_CYCLES cycles, then BYPASS.
- BYPASS: air_ctrl0=1, air_ctrl1=0 for exactly BYPASS_CYCLES cycles, then SETTLE.
- SETTLE: both lines 1 for SETTLE_CYCLES cycles, then:
  - if run_idx+1 == latched n_runs: go to DONE, run_idx unchanged;
  - else: run_idx increments and the sequence returns to LOAD.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. run_idx holds its final value until the next accepted start.
- Timer: counts down from phase length-1 and loads on each phase entry. Phase lengths must fit in TIMER_W bits.
- Interlock invariant: air_ctrl0 and air_ctrl1 are never both 0 in any cycle, including across reset and abort.
- start while busy: ignored, with no effect on any state.
- Changes to n_runs after acceptance: ignored.

Optional Feature:
Macro PCR_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in LOAD, DEAD, BYPASS or SETTLE: the next edge closes both valves and enters DONE.
  - aborted is set to 1 on that edge and stays sticky until the next accepted start clears it.
  - abort in IDLE or DONE is ignored.
  - rst has priority over abort.
- Undefined: neither port exists, and the sequence always runs to completion.

Test Plan:
All scenarios use LOAD=4, DEAD=2, BYPASS=3, SETTLE=2.
- Single run: n_runs=1, start sampled at edge 0.
  - air_ctrl0=0 after edges 0-3; both high after edges 4-5;
  - air_ctrl1=0 after edges 6-8; both high after edges 9-10;
  - done=1 after edge 11 only; busy=0 after edge 12; run_idx=0 throughout.
- Three runs: n_runs=3.
  - LOAD entries after edges 0, 11 and 22; run_idx reads 0, 1, 2;
  - a single done pulse after edge 33.
- Zero runs: n_runs=0 with start -> done pulses after edge 1, and air_ctrl0/air_ctrl1 stay 1 for the whole test.
- Reset and restart:
  - rst asserted during BYPASS -> next edge air_ctrl1=1, busy=0, run_idx=0;
  - restart with n_runs=1 -> full 11-cycle timing as in the single-run case.
- start held high throughout a 2-run sequence with n_runs changed mid-run -> exactly 2 runs; a new sequence is accepted in IDLE after done.
- Abort (PCR_SEQ_ABORT_EN defined): abort pulsed in LOAD after edge 2 -> both lines 1 and done=1 after edge 3; aborted=1 until the next start.

Source files
------------

// File: rtl/pcr_valve_sequencer.sv
// pcr_valve_sequencer
// Drives the two air-control lines of the PCR mixing chip through a fixed
// per-run sequence (load, dead-time, bypass, settle), repeated n_runs times.
// An air line at 1 is pressurised, which closes its valve.
// Optional feature: define PCR_SEQ_ABORT_EN to add the abort input and the
// sticky aborted output.

module pcr_valve_sequencer #(
  parameter int TIMER_W       = 16,
  parameter int RUNS_W        = 8,
  parameter int LOAD_CYCLES   = 1000,
  parameter int DEAD_CYCLES   = 4,
  parameter int BYPASS_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RUNS_W-1:0] n_runs,
`ifdef PCR_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              air_ctrl0,
  output logic              air_ctrl1,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] run_idx
);

  // Timer reload values: each phase counts down from its length minus one.
  localparam logic [TIMER_W-1:0] LOAD_T   = TIMER_W'(LOAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEAD_T   = TIMER_W'(DEAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BYPASS_T = TIMER_W'(BYPASS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_T = TIMER_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DEAD,
    BYPASS,
    SETTLE,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [RUNS_W-1:0]   runs_lat, runs_lat_n;
  logic [RUNS_W-1:0]   run_idx_n;
  logic [RUNS_W:0]     next_idx;
  logic                air_ctrl0_n, air_ctrl1_n, busy_n, done_n;
`ifdef PCR_SEQ_ABORT_EN
  logic                aborted_n;
`endif

  // Next-state, timer, run bookkeeping and the registered output values.
  // Valve outputs are decoded from the next state, so each valve can only be
  // open in its own phase and the two can never be open together.
  // A zero-run request enters DONE with done still low; DONE then raises
  // done on its second cycle, so the pulse lands one cycle after the start.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    runs_lat_n = runs_lat;
    run_idx_n  = run_idx;
    next_idx   = {1'b0, run_idx} + {{RUNS_W{1'b0}}, 1'b1};
`ifdef PCR_SEQ_ABORT_EN
    aborted_n  = aborted;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          run_idx_n = '0;
`ifdef PCR_SEQ_ABORT_EN
          aborted_n = 1'b0;
`endif
          if (n_runs != '0) begin
            runs_lat_n = n_runs;
            state_n    = LOAD;
            timer_n    = LOAD_T;
          end else begin
            state_n    = DONE;
            timer_n    = '0;
          end
        end
      end
      LOAD: begin
        if (timer == '0) begin
          state_n = DEAD;
          timer_n = DEAD_T;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DEAD: begin
        if (timer == '0) begin
          state_n = BYPASS;
          timer_n = BYPASS_T;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      BYPASS: begin
        if (timer == '0) begin
          state_n = SETTLE;
          timer_n = SETTLE_T;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          if (next_idx == {1'b0, runs_lat}) begin
            state_n = DONE;
            timer_n = '0;
          end else begin
            run_idx_n = next_idx[RUNS_W-1:0];
            state_n   = LOAD;
            timer_n   = LOAD_T;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DONE: begin
        if (done) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

`ifdef PCR_SEQ_ABORT_EN
    if (abort && (state == LOAD || state == DEAD ||
                  state == BYPASS || state == SETTLE)) begin
      state_n   = DONE;
      timer_n   = '0;
      aborted_n = 1'b1;
    end
`endif

    air_ctrl0_n = (state_n != LOAD);
    air_ctrl1_n = (state_n != BYPASS);
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE) && (state != IDLE);
  end

  // State and output registers with synchronous reset to the safe idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      runs_lat  <= '0;
      run_idx   <= '0;
      air_ctrl0 <= 1'b1;
      air_ctrl1 <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PCR_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      runs_lat  <= runs_lat_n;
      run_idx   <= run_idx_n;
      air_ctrl0 <= air_ctrl0_n;
      air_ctrl1 <= air_ctrl1_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef PCR_SEQ_ABORT_EN
      aborted   <= aborted_n;
`endif
    end
  end

endmodule

// File: tb/tb_pcr_valve_sequencer.sv
// Testbench for pcr_valve_sequencer with short phase lengths
// (LOAD=4, DEAD=2, BYPASS=3, SETTLE=2). Abort scenarios are built only when
// PCR_SEQ_ABORT_EN is defined.

module tb_pcr_valve_sequencer;

  localparam int L   = 4;
  localparam int D   = 2;
  localparam int B   = 3;
  localparam int S   = 2;
  localparam int RUN = L + D + B + S;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] n_runs;
  logic       air_ctrl0, air_ctrl1, busy, done;
  logic [7:0] run_idx;
`ifdef PCR_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic a0;
    logic a1;
    logic busy;
    logic done;
    int   idx;
  } exp_t;

  typedef struct {
    logic       start;
    logic [7:0] n_runs;
    exp_t       e;
  } vec_t;

  pcr_valve_sequencer #(
    .TIMER_W(16), .RUNS_W(8),
    .LOAD_CYCLES(L), .DEAD_CYCLES(D), .BYPASS_CYCLES(B), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_runs(n_runs),
`ifdef PCR_SEQ_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .air_ctrl0(air_ctrl0),
    .air_ctrl1(air_ctrl1),
    .busy(busy),
    .done(done),
    .run_idx(run_idx)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interlock watch: the two valves must never be open together, so every
  // falling edge is a comparison in its own right.
  always @(negedge clk) begin
    tests_run++;
    if (!air_ctrl0 && !air_ctrl1) begin
      fails++;
      $display("[TB] FAIL interlock at %0t: air_ctrl0=0 air_ctrl1=0, required not both 0", $time);
    end
  end

  // Reference model: outputs k edges after the accepting edge of an n-run
  // request, derived only from the phase lengths and run count.
  function automatic exp_t model(input int n, input int k);
    exp_t e;
    int   p;
    e.a0 = 1'b1; e.a1 = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.idx = 0;
    if (n == 0) begin
      e.busy = (k <= 1);
      e.done = (k == 1);
    end else if (k < RUN * n) begin
      p      = k % RUN;
      e.busy = 1'b1;
      e.idx  = k / RUN;
      e.a0   = !(p < L);
      e.a1   = !(p >= L + D && p < L + D + B);
    end else begin
      e.idx  = n - 1;
      e.busy = (k == RUN * n);
      e.done = (k == RUN * n);
    end
    return e;
  endfunction

  // Advance one rising edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request inputs for the next edge.
  task automatic applyStimulus(input logic s, input logic [7:0] n);
    start  = s;
    n_runs = n;
  endtask

  // Compare all DUT outputs against one expected record.
  task automatic checkOutput(input string name, input exp_t e);
    tests_run++;
    if ({air_ctrl0, air_ctrl1, busy, done} !== {e.a0, e.a1, e.busy, e.done} ||
        int'(run_idx) != e.idx) begin
      fails++;
      $display("[TB] FAIL %s: got a0=%b a1=%b busy=%b done=%b idx=%0d, required a0=%b a1=%b busy=%b done=%b idx=%0d",
               name, air_ctrl0, air_ctrl1, busy, done, run_idx,
               e.a0, e.a1, e.busy, e.done, e.idx);
    end
  endtask

  // Single-bit check, used for the abort flag.
  task automatic checkBit(input string name, input logic act, input logic req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Issue an n-run request and follow it to idle against the model, either
  // with quiet inputs or with random start/n_runs noise that must be ignored.
  task automatic runSeq(input int n, input bit rnd, input string tag);
    int last;
    applyStimulus(1'b1, 8'(n));
    tick();
    last = (n == 0) ? 2 : RUN * n + 1;
    for (int k = 0; k <= last; k++) begin
      checkOutput($sformatf("%s n=%0d k=%0d", tag, n, k), model(n, k));
      if (k < last) begin
        if (rnd) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        else     applyStimulus(1'b0, 8'd0);
        tick();
      end
    end
    applyStimulus(1'b0, 8'd0);
  endtask

  function automatic exp_t mk(input logic a0, input logic a1, input logic b,
                              input logic d, input int idx);
    exp_t e;
    e.a0 = a0; e.a1 = a1; e.busy = b; e.done = d; e.idx = idx;
    return e;
  endfunction

  vec_t tbl[13];
  exp_t idle_e;

  // Main sequence: reset, the single-run table, then the hand-written and
  // randomized scenarios.
  initial begin
    idle_e = mk(1, 1, 0, 0, 0);

    // Single-run expectations after edges 0..12, start asserted at edge 0.
    for (int i = 0; i < 13; i++) begin
      tbl[i].start  = (i == 0);
      tbl[i].n_runs = (i == 0) ? 8'd1 : 8'd0;
    end
    tbl[0].e  = mk(0, 1, 1, 0, 0);
    tbl[1].e  = mk(0, 1, 1, 0, 0);
    tbl[2].e  = mk(0, 1, 1, 0, 0);
    tbl[3].e  = mk(0, 1, 1, 0, 0);
    tbl[4].e  = mk(1, 1, 1, 0, 0);
    tbl[5].e  = mk(1, 1, 1, 0, 0);
    tbl[6].e  = mk(1, 0, 1, 0, 0);
    tbl[7].e  = mk(1, 0, 1, 0, 0);
    tbl[8].e  = mk(1, 0, 1, 0, 0);
    tbl[9].e  = mk(1, 1, 1, 0, 0);
    tbl[10].e = mk(1, 1, 1, 0, 0);
    tbl[11].e = mk(1, 1, 1, 1, 0);
    tbl[12].e = mk(1, 1, 0, 0, 0);

    rst = 1'b1;
    applyStimulus(1'b0, 8'd0);
`ifdef PCR_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset state", idle_e);
`ifdef PCR_SEQ_ABORT_EN
    checkBit("reset aborted", aborted, 1'b0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].start, tbl[i].n_runs);
      tick();
      checkOutput($sformatf("single edge %0d", i), tbl[i].e);
    end

    runSeq(3, 1'b0, "three");
    runSeq(0, 1'b0, "zero");

    // Reset during the second run's bypass phase, then a clean restart.
    applyStimulus(1'b1, 8'd2);
    tick();
    for (int k = 0; k <= 18; k++) begin
      checkOutput($sformatf("prereset k=%0d", k), model(2, k));
      if (k < 18) begin
        applyStimulus(1'b0, 8'd0);
        tick();
      end
    end
    rst = 1'b1;
    tick();
    checkOutput("reset in bypass", idle_e);
    rst = 1'b0;
    runSeq(1, 1'b0, "restart");

    // Start held high throughout; n_runs changes mid-run and must not matter.
    applyStimulus(1'b1, 8'd2);
    tick();
    for (int k = 0; k <= 23; k++) begin
      checkOutput($sformatf("held k=%0d", k), model(2, k));
      if (k == 5) n_runs = 8'd7;
      tick();
    end
    checkOutput("held reaccept", model(7, 0));
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0);
    tick();
    rst = 1'b0;
    tick();

`ifdef PCR_SEQ_ABORT_EN
    // Abort pulsed in LOAD: next edge closes both valves and pulses done.
    applyStimulus(1'b1, 8'd2);
    tick();
    applyStimulus(1'b0, 8'd0);
    tick();
    tick();
    checkOutput("abort pre", model(2, 2));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort edge", mk(1, 1, 1, 1, 0));
    checkBit("aborted set", aborted, 1'b1);
    tick();
    checkOutput("abort idle", idle_e);
    checkBit("aborted sticky", aborted, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkBit("abort in idle ignored", busy, 1'b0);
    applyStimulus(1'b1, 8'd1);
    tick();
    applyStimulus(1'b0, 8'd0);
    checkBit("aborted cleared", aborted, 1'b0);
    checkOutput("post abort start", model(1, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // Randomized requests with random noise on the inputs while busy.
    for (int r = 0; r < 8; r++) begin
      runSeq(int'($urandom_range(0, 4)), 1'b1, "rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
